ifu: RTL and testbench

//  Instruction fetch unit of the single-cycle MIPS core: holds the PC, reads the

---
 rtl/ifu_pkg.sv | 27 ++
 rtl/ifu_npc.sv | 57 +++++
 rtl/ifu.sv | 111 +++++++++++
 tb/tb_ifu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
//  Shared definitions for the instruction fetch unit and the decoder that
//  drives it: next-PC select encodings, default PC base and ROM depth.
//  The ifu build option IFU_STALL_EN is handled in ifu.sv and does not
//  affect anything in this package.
// ----------------------------------------------------------------------------
package ifu_pkg;

    // Next-PC select, produced by decode.
    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,    // pc + 4
        NPC_BR  = 2'b01,    // conditional branch, taken iff zero
        NPC_J   = 2'b10,    // j / jal, 26-bit pseudo-direct target
        NPC_JR  = 2'b11     // jr, register target
    } npc_op_e;

    // Byte address of ROM word 0 and PC value after reset.
    localparam logic [31:0] PC_BASE_DEFAULT  = 32'h0000_3000;

    // ROM depth in 32-bit words; must be a power of two.
    localparam int          IM_WORDS_DEFAULT = 1024;

    // Word returned for any fetch outside the ROM window.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

endpackage

// File: rtl/ifu_npc.sv
// ----------------------------------------------------------------------------
// ifu_npc
//  Pure combinational next-PC logic for the single-cycle MIPS core.
//  Ports:
//    pc          in  32  current PC
//    npc_op      in   2  next-PC select (see ifu_pkg::npc_op_e)
//    zero        in   1  branch condition from the ALU
//    ext_offset  in  32  sign-extended branch offset in words
//    jr_target   in  32  GPR[rs] for jr
//    instr       in  32  instruction at pc (source of the j/jal target)
//    pc_plus4    out 32  pc + 4
//    npc         out 32  next PC
//  All adds wrap modulo 2^32.
// ----------------------------------------------------------------------------
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] ext_offset,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc
);

    logic [31:0] br_target_s;
    logic        unused_bits_s;

    // The word offset is turned into bytes by <<2, so ext_offset[31:30]
    // fall off the top; the sign survives through ext_offset[29].
    assign pc_plus4    = pc + 32'd4;
    assign br_target_s = pc_plus4 + {ext_offset[29:0], 2'b00};

    // Bits that the address arithmetic deliberately ignores.
    assign unused_bits_s = ^{ext_offset[31:30], instr[31:26], jr_target[1:0]};

    // Next-PC select; jr targets are forced word-aligned rather than trapped.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_SEQ: npc = pc_plus4;
            NPC_BR: begin
                if (zero) begin
                    npc = br_target_s;
                end else begin
                    npc = pc_plus4;
                end
            end
            NPC_J:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JR:  npc = {jr_target[31:2], 2'b00};
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/ifu.sv
// ----------------------------------------------------------------------------
// ifu
//  Instruction fetch unit of the single-cycle MIPS core. Holds the PC,
//  reads the instruction ROM combinationally and advances the PC through
//  the ifu_npc sub-module.
//  Parameters:
//    PC_BASE   PC reset value, byte address of ROM word 0
//    IM_WORDS  ROM depth in 32-bit words (power of two)
//    IM_IMAGE  ROM contents, one entry per word; entries not supplied by
//              the integrator default to 32'h0
//  Ports:
//    clk         in   1  rising-edge clock
//    reset       in   1  synchronous, active-high
//    stall       in   1  only with IFU_STALL_EN: hold pc (reset still wins)
//    npc_op      in   2  00 seq, 01 branch, 10 j/jal, 11 jr
//    zero        in   1  branch taken iff npc_op==01 && zero
//    ext_offset  in  32  sign-extended branch offset (words)
//    jr_target   in  32  GPR[rs] for jr
//    instr       out 32  instruction at pc (32'h0 outside the ROM window)
//    pc          out 32  current PC (registered)
//    pc_plus4    out 32  pc + 4, link value for jal
//    fetch_err   out  1  pc outside the ROM window or not word-aligned
//  Build option: define IFU_STALL_EN to add the stall input.
// ----------------------------------------------------------------------------
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] PC_BASE            = PC_BASE_DEFAULT,
    parameter int          IM_WORDS           = IM_WORDS_DEFAULT,
    parameter logic [31:0] IM_IMAGE [IM_WORDS] = '{default: 32'h0}
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IFU_STALL_EN
    input  logic        stall,
`endif
    input  logic [1:0]  npc_op,
    input  logic        zero,
    input  logic [31:0] ext_offset,
    input  logic [31:0] jr_target,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int          IDX_W     = $clog2(IM_WORDS);
    localparam logic [31:0] ROM_BYTES = 32'(IM_WORDS) << 2;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      npc_s;
    logic [31:0]      offset_s;
    logic [IDX_W-1:0] rom_idx_s;
    logic             in_range_s;
    logic             aligned_s;

    ifu_npc u_npc (
        .pc         (pc_q),
        .npc_op     (npc_op),
        .zero       (zero),
        .ext_offset (ext_offset),
        .jr_target  (jr_target),
        .instr      (instr),
        .pc_plus4   (pc_plus4),
        .npc        (npc_s)
    );

    // The window check is done on the true difference: once pc >= PC_BASE
    // the subtraction cannot wrap, so a plain unsigned compare suffices.
    assign offset_s   = pc_q - PC_BASE;
    assign in_range_s = (pc_q >= PC_BASE) && (offset_s < ROM_BYTES);
    assign aligned_s  = (pc_q[1:0] == 2'b00);
    assign rom_idx_s  = offset_s[IDX_W+1:2];

    // ROM read; an invalid fetch yields a nop so the core just falls through.
    always_comb begin
        if (in_range_s && aligned_s) begin
            instr     = IM_IMAGE[rom_idx_s];
            fetch_err = 1'b0;
        end else begin
            instr     = NOP_INSTR;
            fetch_err = 1'b1;
        end
    end

    // Next value of the PC register (stall only exists in the stall build).
    always_comb begin
`ifdef IFU_STALL_EN
        if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = npc_s;
        end
`else
        pc_d = npc_s;
`endif
    end

    // PC register; reset overrides both stall and npc_op.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_BASE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_ifu.sv
// ----------------------------------------------------------------------------
// tb_ifu
//  Self-checking bench for ifu. Each step drives the inputs on the falling
//  edge, queues the state expected after the next rising edge, and pops and
//  compares it 1 ns after that edge.
// ----------------------------------------------------------------------------
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          WORDS = 1024;

    localparam logic [31:0] TB_IMAGE [WORDS] = '{
        0:       32'h2401_0005,
        1:       32'h2402_0007,
        2:       32'h0022_1820,
        3:       32'h1000_FFFE,
        4:       32'h0C00_0C10,
        5:       32'h0000_0000,
        16:      32'h1234_5678,
        255:     32'hDEAD_BEEF,
        default: 32'h0000_0000
    };

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        fe;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        zero;
    logic [31:0] ext_offset;
    logic [31:0] jr_target;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    exp_t        exp_q[$];
    int          n_vec;
    int          n_err;
    logic [31:0] m_pc;

    ifu #(
        .PC_BASE  (BASE),
        .IM_WORDS (WORDS),
        .IM_IMAGE (TB_IMAGE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef IFU_STALL_EN
        .stall      (stall),
`endif
        .npc_op     (npc_op),
        .zero       (zero),
        .ext_offset (ext_offset),
        .jr_target  (jr_target),
        .instr      (instr),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected fetch results derived from the bench's own copy of the image.
    function automatic exp_t make_exp(input string tag, input logic [31:0] epc);
        exp_t e;
        logic [31:0] off;
        e.tag = tag;
        e.pc  = epc;
        e.p4  = epc + 32'd4;
        off   = epc - BASE;
        if (epc >= BASE && epc < BASE + 32'd4096 && epc[1:0] == 2'b00) begin
            e.instr = TB_IMAGE[int'(off >> 2)];
            e.fe    = 1'b0;
        end else begin
            e.instr = 32'h0000_0000;
            e.fe    = 1'b1;
        end
        return e;
    endfunction

    // One clock: drive, queue the expectation, then compare after the edge.
    task automatic step(input string tag, input logic [1:0] op, input logic z,
                        input logic [31:0] ext, input logic [31:0] jr,
                        input logic rst, input logic stl, input logic [31:0] exp_pc);
        exp_t e;
        @(negedge clk);
        npc_op     = op;
        zero       = z;
        ext_offset = ext;
        jr_target  = jr;
        reset      = rst;
        stall      = stl;
        exp_q.push_back(make_exp(tag, exp_pc));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({e.tag, "_pc"},    pc,                 e.pc);
            check({e.tag, "_instr"}, instr,              e.instr);
            check({e.tag, "_p4"},    pc_plus4,           e.p4);
            check({e.tag, "_ferr"},  {31'd0, fetch_err}, {31'd0, e.fe});
        end
    endtask

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  r_op;
        logic        r_z;
        logic [31:0] r_ext;
        logic [31:0] n_pc;

        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        stall      = 1'b0;
        npc_op     = 2'b00;
        zero       = 1'b0;
        ext_offset = 32'h0;
        jr_target  = 32'h0;

        // Reset, then sequential fetch.
        step("reset", 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_3000);
        step("seq1",  2'b00, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3004);
        step("seq2",  2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3008);
        // Taken branch back by two words, then the same branch not taken.
        step("br_t",  2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 32'h0000_3004);
        step("seq3",  2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3008);
        step("br_nt", 2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 32'h0000_300C);
        step("seq4",  2'b00, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 32'h0000_3010);
        // jal at 0x3010 (instr 0C00_0C10).
        step("jal",   2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3040);
        // Misaligned jr target is silently aligned; last ROM word.
        step("jr",    2'b11, 1'b0, 32'h0, 32'h0000_3FFE, 1'b0, 1'b0, 32'h0000_3FFC);
        // One past the ROM window.
        step("oob",   2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_4000);
        step("jr0",   2'b11, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
        // Branch offset with junk in [31:30]: those bits must be dropped.
        step("jr_b",  2'b11, 1'b0, 32'h0, 32'h0000_3100, 1'b0, 1'b0, 32'h0000_3100);
        step("br_hi", 2'b01, 1'b1, 32'hC000_0003, 32'h0, 1'b0, 1'b0, 32'h0000_3110);
        // Wrap across 2^32 stays silent.
        step("jr_w",  2'b11, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'hFFFF_FFFC);
        step("wrap",  2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_0000);
        // Reset mid-run beats a jump request.
        step("rst2",  2'b11, 1'b1, 32'h0, 32'h0000_3800, 1'b1, 1'b1, 32'h0000_3000);

`ifdef IFU_STALL_EN
        step("stl1",  2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0000_3004);
        step("stl2",  2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_3004);
        step("stl3",  2'b11, 1'b0, 32'h0, 32'h0000_3800, 1'b0, 1'b1, 32'h0000_3004);
        step("stl_r", 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0000_3000);
`endif

        // Random seq/branch traffic checked against an address model.
        m_pc = 32'h0000_3000;
        for (int i = 0; i < 12; i++) begin
            r_op  = 2'($urandom_range(0, 1));
            r_z   = 1'($urandom_range(0, 1));
            r_ext = 32'($urandom_range(0, 15)) - 32'd6;
            if (r_op == 2'b01 && r_z) begin
                n_pc = m_pc + 32'd4 + (r_ext * 32'd4);
            end else begin
                n_pc = m_pc + 32'd4;
            end
            step("rnd", r_op, r_z, r_ext, 32'h0, 1'b0, 1'b0, n_pc);
            m_pc = n_pc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
